// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// MEM has priority; a saturating starve counter forces an IF grant after STARVE_MAX MEM wins.
module mem_port_arbiter #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IF_Req,
   input  logic [31:0] IF_Addr,
   output logic        IF_Ready,
   output logic [31:0] IF_Instr,
   output logic        IF_Stall,
   input  logic        MEM_Read,
   input  logic        MEM_Write,
   input  logic [31:0] MEM_Addr,
   input  logic [31:0] MEM_WriteData,
   output logic        MEM_Ready,
   output logic [31:0] MEM_ReadData,
   output logic        MEM_Stall,
   output logic        Mem_En,
   output logic        Mem_We,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_WData,
   input  logic [31:0] Mem_RData
);

   typedef enum logic [1:0] {Idle, Access, Resp} stateT;
   typedef enum logic [1:0] {OwnNone, OwnIf, OwnMem} ownerT;

   stateT      state;
   ownerT      owner;
   logic [3:0] cnt;
   logic [3:0] starveCnt;
   logic       memReq;
   logic       ifWins;

   assign memReq = MEM_Read | MEM_Write;
   assign ifWins = IF_Req & (~memReq | (starveCnt == 4'(STARVE_MAX)));

   assign IF_Stall  = IF_Req & ~IF_Ready;
   assign MEM_Stall = memReq & ~MEM_Ready;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= Idle;
         owner        <= OwnNone;
         cnt          <= 4'd0;
         starveCnt    <= 4'd0;
         Mem_En       <= 1'b0;
         Mem_We       <= 1'b0;
         Mem_Addr     <= 32'd0;
         Mem_WData    <= 32'd0;
         IF_Ready     <= 1'b0;
         MEM_Ready    <= 1'b0;
         IF_Instr     <= 32'd0;
         MEM_ReadData <= 32'd0;
      end else begin
         IF_Ready  <= 1'b0;
         MEM_Ready <= 1'b0;
         unique case (state)
            Idle: begin
               if (memReq || IF_Req) begin
                  state  <= Access;
                  cnt    <= 4'(LATENCY);
                  Mem_En <= 1'b1;
                  if (ifWins) begin
                     owner     <= OwnIf;
                     Mem_Addr  <= IF_Addr;
                     Mem_We    <= 1'b0;
                     starveCnt <= 4'd0;
                  end else begin
                     owner     <= OwnMem;
                     Mem_Addr  <= MEM_Addr;
                     Mem_WData <= MEM_WriteData;
                     Mem_We    <= MEM_Write;
                     if (!IF_Req) begin
                        starveCnt <= 4'd0;
                     end else if (starveCnt < 4'(STARVE_MAX)) begin
                        starveCnt <= starveCnt + 4'd1;
                     end
                  end
               end
            end
            Access: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state  <= Resp;
                  Mem_En <= 1'b0;
                  Mem_We <= 1'b0;
                  // Mem_We still holds the latched write flag here; stores capture nothing.
                  if (owner == OwnIf) begin
                     IF_Ready <= 1'b1;
                     if (!Mem_We) IF_Instr <= Mem_RData;
                  end else begin
                     MEM_Ready <= 1'b1;
                     if (!Mem_We) MEM_ReadData <= Mem_RData;
                  end
               end
            end
            Resp: begin
               state <= Idle;
               owner <= OwnNone;
            end
            default: state <= Idle;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). Sequences each access through a small FSM, returns read data to the winning requester with a one-cycle Ready pulse, and produces per-stage stall signals for the pipeline hazard logic. MEM has priority over IF, and a starvation counter guarantees IF forward progress.

Parameters:
LATENCY, 2, memory read latency in cycles (Mem_En held through access; legal range 1..15)
STARVE_MAX, 4, consecutive MEM grants while IF waits before IF is forced to win (legal range 1..15)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
IF_Req  input  1  fetch request, level, held until IF_Ready
IF_Addr  input  32  fetch byte address
IF_Ready  output  1  one-cycle pulse: IF_Instr valid
IF_Instr  output  32  fetched word (registered)
IF_Stall  output  1  IF_Req & ~IF_Ready
MEM_Read  input  1  load request, level
MEM_Write  input  1  store request, level
MEM_Addr  input  32  load/store byte address
MEM_WriteData  input  32  store data
MEM_Ready  output  1  one-cycle pulse: access complete
MEM_ReadData  output  32  load data (registered)
MEM_Stall  output  1  (MEM_Read|MEM_Write) & ~MEM_Ready
Mem_En  output  1  memory enable
Mem_We  output  1  memory write enable
Mem_Addr  output  32  memory address
Mem_WData  output  32  memory write data
Mem_RData  input  32  memory read data, valid LATENCY cycles after the first Mem_En cycle

Behaviour:
- Clock Clk; reset Reset is asynchronous and active-high.
- Reset (any time, including mid-access): state=IDLE; Mem_En, Mem_We, IF_Ready, MEM_Ready=0; Mem_Addr, Mem_WData, IF_Instr, MEM_ReadData=0; starve counter=0; owner=none. Any in-flight access is abandoned and gets no Ready. Requests still held after release are re-arbitrated from IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: MEM request = MEM_Read|MEM_Write.
  - If MEM request and IF_Req: MEM wins unless starve count == STARVE_MAX, in which case IF wins.
  - Otherwise the sole requester wins.
  - On grant: latch address, write data and write flag (MEM_Write has precedence if both MEM_Read and MEM_Write are high); load cnt=LATENCY; go ACCESS. No request: stay IDLE.
- ACCESS: Mem_En=1; Mem_We=latched write flag; Mem_Addr and Mem_WData held stable from the latched values. cnt decrements each cycle. In the cycle cnt==1: capture Mem_RData into IF_Instr or MEM_ReadData (owner's register only, reads only); next state RESP.
- RESP: Mem_En=0, Mem_We=0; owner's Ready=1 for exactly this cycle; next state IDLE.
- Stores do not modify MEM_ReadData.
- Latency from request seen in IDLE to Ready: LATENCY+2 cycles (1 IDLE + LATENCY ACCESS + RESP pulse cycle). Minimum spacing between grants: LATENCY+2 cycles.
- Starve counter (4 bits):
  - Increments on each MEM grant made while IF_Req=1.
  - Cleared on any IF grant.
  - Cleared on a MEM grant while IF_Req=0.
  - Saturates at STARVE_MAX.
- Handshake: requests are levels sampled only in IDLE. A request still asserted in the cycle after its Ready is treated as a new access; the pipeline must advance or drop the request on Ready.
- Request inputs changing during ACCESS/RESP are ignored until the next IDLE.
- Stalls are combinational from current request and Ready; they deassert in the RESP cycle.

Test Plan:
(LATENCY=2, STARVE_MAX=2; cycle 0 = first edge with request seen in IDLE.)
1. IF_Req=1, IF_Addr=0x10, memory returns 0xDEADBEEF -> Mem_En=1 with Mem_Addr=0x10 cycles 1-2; IF_Ready=1 cycle 3 with IF_Instr=0xDEADBEEF; IF_Stall=1 cycles 0-2, 0 cycle 3.
2. IF_Req and MEM_Read (addr 0x80, data 0xCAFEF00D) together, held until Ready -> MEM_Ready cycle 3 with MEM_ReadData=0xCAFEF00D; IF granted cycle 4; IF_Ready cycle 7.
3. IF_Req held; MEM_Read re-asserted for every access -> MEM wins grants 1 and 2, IF wins grant 3 (cycle 8), starve counter returns to 0.
4. MEM_Write, addr 0x40, data 0x12345678 -> Mem_We=1, Mem_WData=0x12345678 cycles 1-2; MEM_Ready cycle 3; MEM_ReadData unchanged.
5. Reset pulsed during cycle 1 of an IF access -> all outputs 0 asynchronously, no IF_Ready; after release with IF_Req held, access restarts and IF_Ready arrives LATENCY+2 cycles later.
6. MEM_Read=MEM_Write=1 -> write performed (Mem_We=1), MEM_ReadData not updated.
